// File: rtl/clk_div_if.sv
// clk_div_if: channel enables, half-period write port and per-channel outputs of clk_div_prog.
interface clk_div_if #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 9,
    parameter int CH_IDX_W = 1
);
    logic [NUM_CH-1:0]   ch_en;
    logic                wr_en;
    logic [CH_IDX_W-1:0] wr_ch;
    logic [CNT_W-1:0]    wr_data;
    logic [NUM_CH-1:0]   clk_out;
    logic [NUM_CH-1:0]   tick;
    logic [NUM_CH-1:0]   pending;
    modport master(output ch_en, wr_en, wr_ch, wr_data, input clk_out, tick, pending);
    modport slave(input ch_en, wr_en, wr_ch, wr_data, output clk_out, tick, pending);
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable divider with glitch-free deferred half-period loads.
// Optional CLKDIV_SYNC_EN adds sync_i, which phase-aligns all channels.
module clk_div_prog #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 9,
    parameter int RESET_HALF = 499,
    parameter int CH_IDX_W   = 1
) (
    input logic       clk,
    input logic       reset,
`ifdef CLKDIV_SYNC_EN
    input logic       sync_i,
`endif
    clk_div_if.slave  bus
);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt, active_half, shadow;
        logic co, tk, pd, tc, run, wr;
        assign tc = cnt == active_half;
        assign wr = bus.wr_en && bus.wr_ch == CH_IDX_W'(c);
`ifdef CLKDIV_SYNC_EN
        assign run = bus.ch_en[c] && !sync_i;
`else
        assign run = bus.ch_en[c];
`endif
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt         <= '0;
                co          <= 1'b0;
                tk          <= 1'b0;
                pd          <= 1'b0;
                active_half <= CNT_W'(RESET_HALF);
                shadow      <= CNT_W'(RESET_HALF);
            end else begin
`ifdef CLKDIV_SYNC_EN
                if (sync_i) begin
                    cnt <= '0;
                    co  <= 1'b0;
                end
`endif
                tk <= run && tc;
                if (run) begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    co  <= co ^ tc;
                end
                if (run && tc && pd) begin
                    active_half <= shadow;
                    pd          <= 1'b0;
                end
                // a write lands after the terminal count so it is deferred to the next one
                if (wr) begin
                    shadow <= bus.wr_data;
                    pd     <= bus.ch_en[c];
                    if (!bus.ch_en[c]) begin
                        active_half <= bus.wr_data;
                        cnt         <= '0;
                    end
                end
            end
        end
        assign bus.clk_out[c] = co;
        assign bus.tick[c]    = tk;
        assign bus.pending[c] = pd;
    end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: randomized scoreboard bench for clk_div_prog against a countdown reference model.
module tb_clk_div_prog;
    localparam int NUM_CH = 3, CNT_W = 9, RESET_HALF = 499, CH_IDX_W = 2;

    typedef struct {
        logic [NUM_CH-1:0] co, tk, pd;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1;
`ifdef CLKDIV_SYNC_EN
    logic sync_i = 1'b0;
`endif
    clk_div_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_IDX_W(CH_IDX_W)) bus();

    clk_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_HALF(RESET_HALF), .CH_IDX_W(CH_IDX_W)) dut (
        .clk(clk),
        .reset(reset),
`ifdef CLKDIV_SYNC_EN
        .sync_i(sync_i),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int total = 0, bad = 0;
    bit done = 0;

    // model: cycles remaining until the next toggle, reloaded from the half-period
    int rem[NUM_CH], half[NUM_CH], sh[NUM_CH];
    bit pd[NUM_CH], co[NUM_CH], tk[NUM_CH];

    task automatic step(input bit rs, input bit sy, input logic [NUM_CH-1:0] en,
                        input bit we, input int wc, input int wd);
        exp_t e;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rs) begin
                half[c] = RESET_HALF; sh[c] = RESET_HALF; rem[c] = RESET_HALF + 1;
                pd[c] = 0; co[c] = 0; tk[c] = 0;
            end else begin
                tk[c] = 0;
                if (sy) begin
                    co[c] = 0; rem[c] = half[c] + 1;
                end else if (en[c]) begin
                    rem[c]--;
                    if (rem[c] == 0) begin
                        co[c] = !co[c]; tk[c] = 1;
                        if (pd[c]) begin half[c] = sh[c]; pd[c] = 0; end
                        rem[c] = half[c] + 1;
                    end
                end
                if (we && wc == c) begin
                    sh[c] = wd;
                    if (en[c]) pd[c] = 1;
                    else begin half[c] = wd; rem[c] = wd + 1; pd[c] = 0; end
                end
            end
            e.co[c] = co[c]; e.tk[c] = tk[c]; e.pd[c] = pd[c];
        end
        q.push_back(e);
    endtask

    task automatic drive(input bit rs, input bit sy, input logic [NUM_CH-1:0] en,
                         input bit we, input int wc, input int wd);
        @(negedge clk);
        reset = rs;
`ifdef CLKDIV_SYNC_EN
        sync_i = sy;
`endif
        bus.ch_en = en; bus.wr_en = we;
        bus.wr_ch = CH_IDX_W'(wc); bus.wr_data = CNT_W'(wd);
        step(rs, sy, en, we, wc, wd);
    endtask

    task automatic cmp(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                cmp("clk_out", bus.clk_out, e.co);
                cmp("tick", bus.tick, e.tk);
                cmp("pending", bus.pending, e.pd);
            end
        end
    end

    initial begin : stim
        logic [NUM_CH-1:0] en;
        bit we, rs, sy;
        bus.ch_en = '0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0;
        for (int i = 0; i < 3; i++) drive(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 1100; i++) drive(0, 0, '1, 0, 0, 0);
        for (int i = 0; i < 6000; i++) begin
            for (int c = 0; c < NUM_CH; c++) en[c] = $urandom_range(0, 99) < 85;
            we = $urandom_range(0, 99) < 8;
            rs = $urandom_range(0, 999) < 2;
`ifdef CLKDIV_SYNC_EN
            sy = $urandom_range(0, 99) < 1;
`else
            sy = 0;
`endif
            drive(rs, sy, en, we, int'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 7)));
        end
        drive(0, 0, '1, 0, 0, 0);
        drive(1, 0, '1, 0, 0, 0);
        @(posedge clk);
        #2;
        done = 1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
